// File: rtl/game_step_controller.sv
// Game of Life step controller.
// Conditions the two board buttons (synchronise, debounce, edge detect) and
// turns them into the grid's step_game / rst_game pulses. Button 0 toggles
// RUN/PAUSE on a short press and reloads the grid on a long hold; button 1
// single-steps while paused or cycles through four speeds while running.
module game_step_controller #(
  parameter int BASE_DIV      = 23,
  parameter int DEBOUNCE_BITS = 16,
  parameter int HOLD_BITS     = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] buttons,
  output logic       step_game,
  output logic       rst_game,
  output logic       running,
  output logic [1:0] speed
);

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic [DEBOUNCE_BITS-1:0] DEB_MAX  = '1;
  localparam logic [DEBOUNCE_BITS-1:0] DEB_ONE  = DEBOUNCE_BITS'(1);
  localparam logic [HOLD_BITS-1:0]     HOLD_MAX = '1;
  localparam logic [HOLD_BITS-1:0]     HOLD_ONE = HOLD_BITS'(1);
  localparam logic [HOLD_BITS-1:0]     HOLD_ARM = HOLD_MAX - HOLD_ONE;
  localparam logic [BASE_DIV-1:0]      TICK_ALL = '1;
  localparam logic [BASE_DIV-1:0]      TICK_ONE = BASE_DIV'(1);

  state_t                   state;
  logic [1:0]               sync_a;
  logic [1:0]               sync_b;
  logic [DEBOUNCE_BITS-1:0] deb_cnt [2];
  logic [1:0]               deb_level;
  logic [1:0]               deb_level_q;
  logic [1:0]               press_evt;
  logic [1:0]               release_evt;
  logic [HOLD_BITS-1:0]     hold_cnt;
  logic                     hold_active;
  logic [BASE_DIV-1:0]      tick_cnt;
  logic [BASE_DIV-1:0]      tick_max;
  logic                     long_fire;
  logic                     short_release;

  // Faster speeds halve the tick period, so the terminal count shrinks by one bit per step.
  assign tick_max = TICK_ALL >> speed;

  // Long press fires on the cycle the hold counter reaches its top value with the button still down.
  assign long_fire = hold_active && deb_level[0] && (hold_cnt == HOLD_ARM);

  // A release counts as a short press only if the long-hold reset has not already fired.
  assign short_release = release_evt[0] && hold_active && (hold_cnt != HOLD_MAX);

  assign running = (state == RUN);

  // Two-flop synchroniser for the asynchronous pushbuttons.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= buttons;
      sync_b <= sync_a;
    end
  end

  // Debounce: the level only flips once the synced input has disagreed with it long enough.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        deb_cnt[i] <= '0;
      end
      deb_level <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == deb_level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          deb_level[i] <= ~deb_level[i];
          deb_cnt[i]   <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_ONE;
        end
      end
    end
  end

  // Registered one-cycle press and release events from the debounced levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_level_q <= '0;
      press_evt   <= '0;
      release_evt <= '0;
    end else begin
      deb_level_q <= deb_level;
      press_evt   <= deb_level & ~deb_level_q;
      release_evt <= ~deb_level & deb_level_q;
    end
  end

  // Button 0 hold timer: restarts on each press and saturates so a long hold fires only once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_active <= 1'b0;
      hold_cnt    <= '0;
    end else if (press_evt[0]) begin
      hold_active <= 1'b1;
      hold_cnt    <= '0;
    end else if (release_evt[0]) begin
      hold_active <= 1'b0;
    end else if (hold_active && deb_level[0] && (hold_cnt != HOLD_MAX)) begin
      hold_cnt <= hold_cnt + HOLD_ONE;
    end
  end

  // RUN/PAUSE state, speed, tick divider and the two output pulses, highest priority first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= PAUSE;
      speed     <= 2'd0;
      tick_cnt  <= '0;
      step_game <= 1'b0;
      rst_game  <= 1'b0;
    end else begin
      step_game <= 1'b0;
      rst_game  <= 1'b0;
      if (long_fire) begin
        rst_game <= 1'b1;
        state    <= PAUSE;
        tick_cnt <= '0;
      end else if (short_release) begin
        state    <= (state == RUN) ? PAUSE : RUN;
        tick_cnt <= '0;
      end else if (press_evt[1]) begin
        if (state == PAUSE) begin
          step_game <= 1'b1;
        end else begin
          speed    <= speed + 2'd1;
          tick_cnt <= '0;
        end
      end else if (state == RUN) begin
        if (tick_cnt == tick_max) begin
          step_game <= 1'b1;
          tick_cnt  <= '0;
        end else begin
          tick_cnt <= tick_cnt + TICK_ONE;
        end
      end else begin
        tick_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_game_step_controller.sv
// Testbench for game_step_controller with small divider/debounce/hold widths.
// A cycle-level behavioural model of the control rules predicts every
// step_game / rst_game pulse into a scoreboard queue; a monitor pops and
// compares on each pulse. A vector table drives the speed/period checks.
module tb_game_step_controller;

  localparam int BASE_DIV      = 4;
  localparam int DEBOUNCE_BITS = 2;
  localparam int HOLD_BITS     = 4;

  // Event latency from a raw edge driven at cycle c: action lands on cycle c+8.
  localparam int EVT_LAT   = 8;
  // Long hold fires 16 cycles after the press event (event at c+7).
  localparam int LONG_LAT  = 23;

  localparam int EV_STEP    = 0;
  localparam int EV_RST     = 1;
  localparam int ACT_B1     = 0;
  localparam int ACT_TOGGLE = 1;
  localparam int ACT_LONG   = 2;

  typedef struct {
    int kind;
    int at;
  } event_t;

  typedef struct {
    bit press_b1;
    int speed;
    int period;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] buttons;
  logic       step_game;
  logic       rst_game;
  logic       running;
  logic [1:0] speed;

  event_t exp_q [$];
  event_t act_q [$];
  int     cyc = 0;
  int     tests_run = 0;
  int     tests_failed = 0;
  int     overlap_cnt = 0;
  int     steps_seen = 0;
  bit     m_run;
  int     m_speed;
  int     m_clear;

  game_step_controller #(
    .BASE_DIV      (BASE_DIV),
    .DEBOUNCE_BITS (DEBOUNCE_BITS),
    .HOLD_BITS     (HOLD_BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .buttons   (buttons),
    .step_game (step_game),
    .rst_game  (rst_game),
    .running   (running),
    .speed     (speed)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports each mismatch.
  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press one button for hold_cycles and schedule the control action it should cause.
  task automatic applyStimulus(input int btn, input int hold_cycles);
    event_t a;
    int c;
    c = cyc;
    buttons[btn] = 1'b1;
    if (btn == 1) begin
      a.kind = ACT_B1;
      a.at   = c + EVT_LAT;
    end else if (hold_cycles >= 20) begin
      a.kind = ACT_LONG;
      a.at   = c + LONG_LAT;
    end else begin
      a.kind = ACT_TOGGLE;
      a.at   = c + hold_cycles + EVT_LAT;
    end
    act_q.push_back(a);
    repeat (hold_cycles) @(negedge clk);
    buttons[btn] = 1'b0;
  endtask

  task automatic wait_step(output int at);
    at = -1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (step_game) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic check_sb_empty(input string name);
    checkOutput(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Behavioural model: applies scheduled actions by priority, otherwise predicts RUN ticks.
  initial begin : model
    event_t e;
    bit has_long, has_tog, has_b1;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        m_run   = 1'b0;
        m_speed = 0;
        m_clear = cyc;
        act_q.delete();
      end else begin
        has_long = 1'b0;
        has_tog  = 1'b0;
        has_b1   = 1'b0;
        for (int i = act_q.size() - 1; i >= 0; i--) begin
          if (act_q[i].at == cyc) begin
            if (act_q[i].kind == ACT_LONG)   has_long = 1'b1;
            if (act_q[i].kind == ACT_TOGGLE) has_tog  = 1'b1;
            if (act_q[i].kind == ACT_B1)     has_b1   = 1'b1;
            act_q.delete(i);
          end
        end
        if (has_long) begin
          e.kind = EV_RST;
          e.at   = cyc;
          exp_q.push_back(e);
          m_run   = 1'b0;
          m_clear = cyc;
        end else if (has_tog) begin
          m_run   = !m_run;
          m_clear = cyc;
        end else if (has_b1) begin
          if (!m_run) begin
            e.kind = EV_STEP;
            e.at   = cyc;
            exp_q.push_back(e);
          end else begin
            m_speed = (m_speed + 1) % 4;
          end
          m_clear = cyc;
        end else if (m_run && ((cyc - m_clear) % (1 << (BASE_DIV - m_speed)) == 0)) begin
          e.kind = EV_STEP;
          e.at   = cyc;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Monitor: every output pulse must match the next predicted pulse in kind and cycle.
  initial begin : monitor
    event_t e;
    forever begin
      @(negedge clk);
      if (step_game && rst_game) overlap_cnt++;
      if (step_game) steps_seen++;
      if (step_game || rst_game) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_pulse: got step_game=%0b rst_game=%0b at cycle %0d, expected no pulse",
                   step_game, rst_game, cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pulse_kind", step_game ? EV_STEP : EV_RST, e.kind);
          checkOutput("pulse_cycle", cyc, e.at);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got no finish by cycle %0d, expected finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    vec_t vecs [5];
    int   r, c, p1, p2, steps_before;

    vecs[0] = '{press_b1: 1'b0, speed: 0, period: 16};
    vecs[1] = '{press_b1: 1'b1, speed: 1, period: 8};
    vecs[2] = '{press_b1: 1'b1, speed: 2, period: 4};
    vecs[3] = '{press_b1: 1'b1, speed: 3, period: 2};
    vecs[4] = '{press_b1: 1'b1, speed: 0, period: 16};

    // Reset with both buttons held: outputs idle, events only after full debounce.
    rst     = 1'b0;
    buttons = 2'b11;
    wait_cycles(3);
    checkOutput("reset_step_game", int'(step_game), 0);
    checkOutput("reset_rst_game", int'(rst_game), 0);
    checkOutput("reset_running", int'(running), 0);
    checkOutput("reset_speed", int'(speed), 0);
    r   = cyc;
    rst = 1'b1;
    act_q.push_back('{kind: ACT_B1, at: r + EVT_LAT});
    act_q.push_back('{kind: ACT_LONG, at: r + LONG_LAT});
    wait_cycles(7);
    checkOutput("no_early_event", int'(step_game), 0);
    wait_cycles(1);
    checkOutput("first_event_step", int'(step_game), 1);
    wait_cycles(22);
    buttons = 2'b00;
    wait_cycles(16);
    checkOutput("reset_release_ignored", int'(running), 0);
    check_sb_empty("sb_empty_reset");

    // Bouncing b1 while paused gives exactly one step once it settles high.
    steps_before = steps_seen;
    c = cyc;
    act_q.push_back('{kind: ACT_B1, at: c + 20 + EVT_LAT});
    for (int i = 0; i < 10; i++) begin
      buttons[1] = (i % 2 == 0);
      wait_cycles(2);
    end
    buttons[1] = 1'b1;
    wait_cycles(12);
    buttons[1] = 1'b0;
    wait_cycles(16);
    checkOutput("bounce_step_count", steps_seen - steps_before, 1);
    check_sb_empty("sb_empty_bounce");

    // Short b0 press enters RUN, then b1 presses walk the speed table.
    applyStimulus(0, 6);
    wait_cycles(10);
    checkOutput("run_after_short", int'(running), 1);
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].press_b1) applyStimulus(1, 6);
      wait_cycles(10);
      checkOutput("table_speed", int'(speed), vecs[i].speed);
      wait_step(p1);
      wait_step(p2);
      checkOutput("table_period", p2 - p1, vecs[i].period);
    end
    check_sb_empty("sb_empty_run");

    // Long hold in RUN reloads the grid, pauses, ignores the release and keeps speed.
    applyStimulus(1, 6);
    wait_cycles(10);
    applyStimulus(0, 30);
    wait_cycles(20);
    checkOutput("long_running", int'(running), 0);
    checkOutput("long_speed_kept", int'(speed), 1);
    check_sb_empty("sb_empty_long");

    // Toggle to PAUSE landing exactly on a speed-3 tick: the tick is dropped.
    applyStimulus(0, 6);
    wait_cycles(10);
    applyStimulus(1, 6);
    wait_cycles(10);
    applyStimulus(1, 6);
    wait_cycles(10);
    checkOutput("collision_speed", int'(speed), 3);
    if (((cyc - m_clear) % 2) != 0) wait_cycles(1);
    c = cyc;
    applyStimulus(0, 6);
    wait_cycles(7);
    checkOutput("collision_pre_running", int'(running), 1);
    wait_cycles(1);
    checkOutput("collision_cycle", cyc, c + 14);
    checkOutput("collision_no_step", int'(step_game), 0);
    checkOutput("collision_running", int'(running), 0);
    wait_cycles(16);
    check_sb_empty("sb_empty_collision");

    // Reset mid-hold discards progress; the still-held button re-debounces from scratch.
    buttons[0] = 1'b1;
    wait_cycles(10);
    rst = 1'b0;
    wait_cycles(2);
    checkOutput("midrst_rst_game", int'(rst_game), 0);
    checkOutput("midrst_speed", int'(speed), 0);
    checkOutput("midrst_running", int'(running), 0);
    r   = cyc;
    rst = 1'b1;
    act_q.push_back('{kind: ACT_LONG, at: r + LONG_LAT});
    wait_cycles(30);
    buttons[0] = 1'b0;
    wait_cycles(16);
    checkOutput("midrst_release_ignored", int'(running), 0);
    check_sb_empty("sb_empty_midrst");

    checkOutput("step_rst_overlap", overlap_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
